// File: rtl/parking_lot_param.sv
// Automated parking lot controller: a single elevator shuttles cars between the
// entrance (floor 0) and FLOORS parking floors of SLOTS slots each.
module parking_lot_param #(
  parameter int FLOORS  = 7,
  parameter int SLOTS   = 4,
  parameter int PLATE_W = 16,
  parameter int FEE_W   = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [PLATE_W-1:0]                license_plate,
  input  logic                              in_mode,
  input  logic                              out_mode,
  input  logic                              leakage,
  input  logic [2:0]                        leakage_floor,
  output logic [FLOORS*SLOTS*PLATE_W-1:0]   parked,
  output logic [2:0]                        current_floor,
  output logic [PLATE_W-1:0]                moving,
  output logic                              req_ready,
  output logic [FEE_W-1:0]                  fee,
  output logic                              fee_valid,
  output logic                              reject,
  output logic [6:0]                        empty_count,
  output logic                              full
);

  localparam int NSLOT = FLOORS * SLOTS;
  localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  // IDLE: accepts requests | UP: climbing to target floor | DOWN: returning to entrance
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cur_floor_q, cur_floor_d;
  logic [2:0]         tgt_floor_q, tgt_floor_d;
  logic [IW-1:0]      tgt_idx_q, tgt_idx_d;
  logic               op_out_q, op_out_d;
  logic [PLATE_W-1:0] moving_q, moving_d;
  logic [FEE_W-1:0]   fee_q, fee_d;
  logic               fee_valid_q, fee_valid_d;
  logic               reject_q, reject_d;
  logic [PLATE_W-1:0] slot_q [NSLOT];
  logic [PLATE_W-1:0] slot_d [NSLOT];
  logic [FEE_W-1:0]   age_q  [NSLOT];
  logic [FEE_W-1:0]   age_d  [NSLOT];

  logic               alloc_found, hit_found;
  logic [2:0]         alloc_floor, hit_floor;
  logic [IW-1:0]      alloc_idx, hit_idx;
  logic [6:0]         empties;
  logic               plate_zero, accept_in, accept_out, refuse;

  // Lowest free slot on a non-leaking floor, location of the requested plate, free count
  always_comb begin
    alloc_found = 1'b0;
    alloc_floor = '0;
    alloc_idx   = '0;
    hit_found   = 1'b0;
    hit_floor   = '0;
    hit_idx     = '0;
    empties     = '0;
    for (int f = 1; f <= FLOORS; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_q[(f-1)*SLOTS+s] == '0) begin
          empties = empties + 7'd1;
          if (!alloc_found && !(leakage && leakage_floor == 3'(f))) begin
            alloc_found = 1'b1;
            alloc_floor = 3'(f);
            alloc_idx   = IW'((f-1)*SLOTS+s);
          end
        end else if (!hit_found && slot_q[(f-1)*SLOTS+s] == license_plate) begin
          hit_found = 1'b1;
          hit_floor = 3'(f);
          hit_idx   = IW'((f-1)*SLOTS+s);
        end
      end
    end
  end

  assign plate_zero = (license_plate == '0);
  assign accept_out = (state_q == IDLE) && out_mode && !plate_zero && hit_found;
  assign accept_in  = (state_q == IDLE) && in_mode && !out_mode && !plate_zero &&
                      !hit_found && alloc_found;
  assign refuse     = (state_q == IDLE) && (in_mode || out_mode) && !accept_out && !accept_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      tgt_floor_q <= '0;
      tgt_idx_q   <= '0;
      op_out_q    <= 1'b0;
      moving_q    <= '0;
      fee_q       <= '0;
      fee_valid_q <= 1'b0;
      reject_q    <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      tgt_floor_q <= tgt_floor_d;
      tgt_idx_q   <= tgt_idx_d;
      op_out_q    <= op_out_d;
      moving_q    <= moving_d;
      fee_q       <= fee_d;
      fee_valid_q <= fee_valid_d;
      reject_q    <= reject_d;
      for (int i = 0; i < NSLOT; i++) begin
        slot_q[i] <= slot_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_in || accept_out) state_d = UP;
      UP:      if (cur_floor_q == tgt_floor_q) state_d = DOWN;
      DOWN:    if (cur_floor_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_floor_d = cur_floor_q;
    tgt_floor_d = tgt_floor_q;
    tgt_idx_d   = tgt_idx_q;
    op_out_d    = op_out_q;
    moving_d    = moving_q;
    fee_d       = fee_q;
    fee_valid_d = 1'b0;
    reject_d    = refuse;
    for (int i = 0; i < NSLOT; i++) begin
      slot_d[i] = slot_q[i];
      age_d[i]  = (slot_q[i] != '0 && age_q[i] != '1) ? age_q[i] + 1'b1 : age_q[i];
    end
    case (state_q)
      IDLE: begin
        if (accept_out) begin
          tgt_floor_d = hit_floor;
          tgt_idx_d   = hit_idx;
          op_out_d    = 1'b1;
        end else if (accept_in) begin
          tgt_floor_d = alloc_floor;
          tgt_idx_d   = alloc_idx;
          op_out_d    = 1'b0;
          moving_d    = license_plate;
        end
      end
      UP: begin
        if (cur_floor_q == tgt_floor_q) begin
          if (op_out_q) begin
            moving_d          = slot_q[tgt_idx_q];
            fee_d             = age_q[tgt_idx_q];
            slot_d[tgt_idx_q] = '0;
          end else begin
            slot_d[tgt_idx_q] = moving_q;
            age_d[tgt_idx_q]  = '0;
            moving_d          = '0;
          end
        end else begin
          cur_floor_d = cur_floor_q + 3'd1;
        end
      end
      DOWN: begin
        if (cur_floor_q == 3'd0) begin
          moving_d    = '0;
          fee_valid_d = op_out_q;
        end else begin
          cur_floor_d = cur_floor_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    parked = '0;
    for (int i = 0; i < NSLOT; i++) parked[i*PLATE_W +: PLATE_W] = slot_q[i];
  end

  assign current_floor = cur_floor_q;
  assign moving        = moving_q;
  assign req_ready     = (state_q == IDLE);
  assign fee           = fee_q;
  assign fee_valid     = fee_valid_q;
  assign reject        = reject_q;
  assign empty_count   = empties;
  assign full          = !alloc_found;

endmodule

// File: tb/tb_parking_lot_param.sv
// Bench for parking_lot_param: table of requests with hand-computed targets,
// plus sequences for the leak-full lot and reset during a trip.
module tb_parking_lot_param;
  localparam int FL = 7;
  localparam int SL = 4;
  localparam int PW = 16;
  localparam int FW = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic [PW-1:0]       license_plate;
  logic                in_mode, out_mode, leakage;
  logic [2:0]          leakage_floor;
  logic [FL*SL*PW-1:0] parked;
  logic [2:0]          current_floor;
  logic [PW-1:0]       moving;
  logic                req_ready;
  logic [FW-1:0]       fee;
  logic                fee_valid, reject;
  logic [6:0]          empty_count;
  logic                full;

  logic [PW-1:0]       s_plate;
  logic                s_in, s_out, s_leak;
  logic [2:0]          s_lf;
  logic [PW-1:0]       s_parked;
  logic [2:0]          s_cf;
  logic [PW-1:0]       s_moving;
  logic                s_ready;
  logic [FW-1:0]       s_fee;
  logic                s_fv, s_rej;
  logic [6:0]          s_empty;
  logic                s_full;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int store_cyc [int];
  int last_fee = 0;

  parking_lot_param #(.FLOORS(FL), .SLOTS(SL), .PLATE_W(PW), .FEE_W(FW)) dut (
    .clock(clock), .reset(reset), .license_plate(license_plate), .in_mode(in_mode),
    .out_mode(out_mode), .leakage(leakage), .leakage_floor(leakage_floor), .parked(parked),
    .current_floor(current_floor), .moving(moving), .req_ready(req_ready), .fee(fee),
    .fee_valid(fee_valid), .reject(reject), .empty_count(empty_count), .full(full));

  // One-floor, one-slot lot so that every floor can be leaking at once
  parking_lot_param #(.FLOORS(1), .SLOTS(1), .PLATE_W(PW), .FEE_W(FW)) u_small (
    .clock(clock), .reset(reset), .license_plate(s_plate), .in_mode(s_in),
    .out_mode(s_out), .leakage(s_leak), .leakage_floor(s_lf), .parked(s_parked),
    .current_floor(s_cf), .moving(s_moving), .req_ready(s_ready), .fee(s_fee),
    .fee_valid(s_fv), .reject(s_rej), .empty_count(s_empty), .full(s_full));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  typedef struct {
    logic          im;
    logic          om;
    logic [PW-1:0] plate;
    logic          lk;
    logic [2:0]    lf;
    logic          noise;
    logic          rej;
    int            f;
    int            s;
    int            empty;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic im, input logic om, input logic [PW-1:0] plate,
                              input logic lk, input logic [2:0] lf, input logic noise,
                              input logic rej, input int f, input int s, input int empty);
    vec_t v;
    v.im = im; v.om = om; v.plate = plate; v.lk = lk; v.lf = lf; v.noise = noise;
    v.rej = rej; v.f = f; v.s = s; v.empty = empty;
    return v;
  endfunction

  function automatic logic [PW-1:0] slot_at(input int f, input int s);
    return parked[((f-1)*SL+s)*PW +: PW];
  endfunction

  task automatic run_req(input vec_t v);
    int tot, ef, exp_fee;
    exp_fee = last_fee;
    license_plate = v.plate; in_mode = v.im; out_mode = v.om;
    leakage = v.lk; leakage_floor = v.lf;
    check("ready_before", 64'(req_ready), 64'(1));
    @(posedge clock); #1;
    in_mode = 1'b0; out_mode = 1'b0;
    if (v.rej) begin
      check("reject_pulse", 64'(reject), 64'(1));
      check("rej_ready", 64'(req_ready), 64'(1));
      check("rej_floor", 64'(current_floor), 64'(0));
      check("rej_moving", 64'(moving), 64'(0));
      @(posedge clock); #1;
      check("reject_clear", 64'(reject), 64'(0));
      check("rej_ready2", 64'(req_ready), 64'(1));
    end else begin
      check("acc_reject", 64'(reject), 64'(0));
      check("acc_ready", 64'(req_ready), 64'(0));
      check("acc_moving", 64'(moving), v.om ? 64'(0) : 64'(v.plate));
      tot = 2*v.f + 2;
      if (v.noise) begin
        in_mode = 1'b1; out_mode = 1'b1; license_plate = 16'h9423;
      end
      for (int n = 1; n <= tot; n++) begin
        @(posedge clock); #1;
        if (n <= v.f)            ef = n;
        else if (n == v.f + 1)   ef = v.f;
        else if (2*v.f+1-n > 0)  ef = 2*v.f + 1 - n;
        else                     ef = 0;
        check("trip_floor", 64'(current_floor), 64'(ef));
        check("trip_noreject", 64'(reject), 64'(0));
        check("trip_ready", 64'(req_ready), 64'(n == tot));
        if (n == v.f + 1) begin
          if (v.om) begin
            check("out_slot_clear", 64'(slot_at(v.f, v.s)), 64'(0));
            check("out_moving", 64'(moving), 64'(v.plate));
            exp_fee = cyc - store_cyc[int'(v.plate)] - 1;
          end else begin
            check("in_slot_store", 64'(slot_at(v.f, v.s)), 64'(v.plate));
            check("in_moving_clear", 64'(moving), 64'(0));
            store_cyc[int'(v.plate)] = cyc;
          end
        end
        if (v.noise && n == tot - 1) begin
          in_mode = 1'b0; out_mode = 1'b0;
        end
      end
      check("done_moving", 64'(moving), 64'(0));
      check("done_fee_valid", 64'(fee_valid), 64'(v.om));
      last_fee = exp_fee;
      @(posedge clock); #1;
      check("fee_valid_clear", 64'(fee_valid), 64'(0));
    end
    check("fee_held", 64'(fee), 64'(last_fee));
    check("empty_count", 64'(empty_count), 64'(v.empty));
  endtask

  initial begin
    vt[0]  = mk(1, 0, 16'h9423, 0, 0, 0, 0, 1, 0, 27);
    vt[1]  = mk(1, 0, 16'h8754, 1, 1, 0, 0, 2, 0, 26);
    vt[2]  = mk(1, 0, 16'h1111, 0, 0, 0, 0, 1, 1, 25);
    vt[3]  = mk(1, 0, 16'h3891, 0, 0, 0, 0, 1, 2, 24);
    vt[4]  = mk(1, 0, 16'h2222, 0, 0, 0, 0, 1, 3, 23);
    vt[5]  = mk(1, 0, 16'h4444, 0, 0, 0, 0, 2, 1, 22);
    vt[6]  = mk(0, 1, 16'h3891, 0, 0, 0, 0, 1, 2, 23);
    vt[7]  = mk(0, 1, 16'h7777, 0, 0, 0, 1, 0, 0, 23);
    vt[8]  = mk(1, 0, 16'h1111, 0, 0, 0, 1, 0, 0, 23);
    vt[9]  = mk(1, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 23);
    vt[10] = mk(0, 1, 16'h0000, 0, 0, 0, 1, 0, 0, 23);
    vt[11] = mk(1, 1, 16'h2222, 0, 0, 0, 0, 1, 3, 24);
    vt[12] = mk(0, 1, 16'h8754, 1, 2, 0, 0, 2, 0, 25);
    vt[13] = mk(1, 0, 16'h5555, 1, 1, 0, 0, 2, 0, 24);
    vt[14] = mk(1, 0, 16'h6001, 0, 0, 1, 0, 1, 2, 23);
    vt[15] = mk(1, 0, 16'h6002, 0, 0, 0, 0, 1, 3, 22);
    vt[16] = mk(1, 0, 16'h6003, 0, 0, 0, 0, 2, 2, 21);
    vt[17] = mk(1, 0, 16'h6004, 0, 0, 0, 0, 2, 3, 20);

    reset = 1'b1;
    license_plate = '0; in_mode = 1'b0; out_mode = 1'b0; leakage = 1'b0; leakage_floor = '0;
    s_plate = '0; s_in = 1'b0; s_out = 1'b0; s_leak = 1'b0; s_lf = '0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_floor", 64'(current_floor), 64'(0));
    check("rst_moving", 64'(moving), 64'(0));
    check("rst_parked", 64'(parked == '0), 64'(1));
    check("rst_empty", 64'(empty_count), 64'(28));
    check("rst_full", 64'(full), 64'(0));
    check("rst_fee", 64'(fee), 64'(0));
    check("rst_fee_valid", 64'(fee_valid), 64'(0));
    check("rst_reject", 64'(reject), 64'(0));

    // Single-floor lot with its only floor leaking: nothing allocatable
    s_plate = 16'h8754; s_leak = 1'b1; s_lf = 3'd1;
    #1;
    check("small_full", 64'(s_full), 64'(1));
    check("small_empty", 64'(s_empty), 64'(1));
    s_in = 1'b1;
    @(posedge clock); #1;
    s_in = 1'b0;
    check("small_reject", 64'(s_rej), 64'(1));
    check("small_ready", 64'(s_ready), 64'(1));
    check("small_parked", 64'(s_parked), 64'(0));
    check("small_floor", 64'(s_cf), 64'(0));
    @(posedge clock); #1;
    check("small_reject_clear", 64'(s_rej), 64'(0));
    s_leak = 1'b0;
    #1;
    check("small_not_full", 64'(s_full), 64'(0));

    for (int i = 0; i < 18; i++) run_req(vt[i]);
    check("noise_kept_9423", 64'(slot_at(1, 0)), 64'(16'h9423));

    // Reset while the elevator carries 6005 past floor 3
    license_plate = 16'h6005; in_mode = 1'b1; leakage = 1'b0;
    @(posedge clock); #1;
    in_mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("trip3_floor", 64'(current_floor), 64'(3));
    check("trip3_moving", 64'(moving), 64'(16'h6005));
    reset = 1'b1;
    #1;
    check("arst_floor", 64'(current_floor), 64'(0));
    check("arst_moving", 64'(moving), 64'(0));
    check("arst_parked", 64'(parked == '0), 64'(1));
    check("arst_ready", 64'(req_ready), 64'(1));
    check("arst_empty", 64'(empty_count), 64'(28));
    check("arst_fee", 64'(fee), 64'(0));
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    last_fee = 0;
    run_req(mk(1, 0, 16'h7001, 0, 0, 0, 0, 1, 0, 27));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
